// File: rtl/snake_move_ctrl_pkg.sv
// Shared types for the snake head controller and the next-head helper.
// Holds direction and state encodings plus the coordinate width.
package snake_move_ctrl_pkg;

    localparam int COORD_W = 7;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        RIGHT = 2'd2,
        LEFT  = 2'd3
    } way_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DEAD  = 2'd3
    } state_t;

    // Encodings pair up as {UP,DOWN} and {RIGHT,LEFT}, so the LSB flips.
    function automatic way_t opposite(input way_t w);
        return way_t'(w ^ 2'b01);
    endfunction

endpackage

// File: rtl/snake_next_head.sv
// Combinational next-head computation, also used by renderer preview.
// Ports: i_X/i_Y head, i_Way heading -> o_X/o_Y next head (7-bit wrap).
module snake_next_head
    import snake_move_ctrl_pkg::*;
(
    input  coord_t i_X,
    input  coord_t i_Y,
    input  way_t   i_Way,
    output coord_t o_X,
    output coord_t o_Y
);

    localparam coord_t ONE = COORD_W'(1);

    always_comb begin
        o_X = i_X;
        o_Y = i_Y;
        unique case (i_Way)
            UP:    o_X = i_X - ONE;
            DOWN:  o_X = i_X + ONE;
            LEFT:  o_Y = i_Y - ONE;
            RIGHT: o_Y = i_Y + ONE;
        endcase
    end

endmodule

// File: rtl/snake_move_ctrl.sv
// Snake head controller: step timer, push buffer, reversal filter, walls.
// Ports: i_Clk/i_Rst, i_Start, i_Push_Valid/i_Push, i_Hit ->
//        o_Head_x/o_Head_y, o_Way, o_Step, o_Dead, o_State.
module snake_move_ctrl
    import snake_move_ctrl_pkg::*;
#(
    parameter int TICKS_PER_STEP = 5_000_000,
    parameter int ROWS           = 48,
    parameter int COLS           = 64,
    parameter int START_X        = 24,
    parameter int START_Y        = 32
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic               i_Start,
    input  logic               i_Push_Valid,
    input  logic [1:0]         i_Push,
    input  logic               i_Hit,
    output logic [COORD_W-1:0] o_Head_x,
    output logic [COORD_W-1:0] o_Head_y,
    output logic [1:0]         o_Way,
    output logic               o_Step,
    output logic               o_Dead,
    output logic [1:0]         o_State
);

    localparam int CNT_W = $clog2(TICKS_PER_STEP);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_STEP - 1);
    localparam coord_t ROWS_C  = COORD_W'(ROWS);
    localparam coord_t COLS_C  = COORD_W'(COLS);
    localparam coord_t START_XC = COORD_W'(START_X);
    localparam coord_t START_YC = COORD_W'(START_Y);

    state_t           r_state, w_state_nxt;
    coord_t           r_x, w_x_nxt;
    coord_t           r_y, w_y_nxt;
    way_t             r_way, w_way_nxt;
    logic             r_step, w_step_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    way_t             r_pend, w_pend_nxt;
    logic             r_pend_vld, w_pend_vld_nxt;

    logic             w_tick;
    logic [CNT_W-1:0] w_cnt_inc;
    way_t             w_eff_way;
    coord_t           w_nx, w_ny;
    logic             w_wall;

    assign w_tick    = (r_cnt == CNT_LAST);
    assign w_cnt_inc = w_tick ? '0 : r_cnt + CNT_W'(1);

    // Reversal filter is against the committed heading only.
    assign w_eff_way = (r_pend_vld && (r_pend != opposite(r_way)))
                     ? r_pend : r_way;

    snake_next_head u_next_head (
        .i_X   (r_x),
        .i_Y   (r_y),
        .i_Way (w_eff_way),
        .o_X   (w_nx),
        .o_Y   (w_ny)
    );

    // Underflow wraps to 127, so one unsigned compare catches both edges.
    assign w_wall = (w_nx >= ROWS_C) || (w_ny >= COLS_C);

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_state    <= IDLE;
            r_x        <= START_XC;
            r_y        <= START_YC;
            r_way      <= RIGHT;
            r_step     <= 1'b0;
            r_cnt      <= '0;
            r_pend     <= UP;
            r_pend_vld <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_x        <= w_x_nxt;
            r_y        <= w_y_nxt;
            r_way      <= w_way_nxt;
            r_step     <= w_step_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_vld <= w_pend_vld_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_x_nxt        = r_x;
        w_y_nxt        = r_y;
        w_way_nxt      = r_way;
        w_step_nxt     = 1'b0;
        w_cnt_nxt      = r_cnt;
        w_pend_nxt     = r_pend;
        w_pend_vld_nxt = r_pend_vld;

        unique case (r_state)
            IDLE, DEAD: begin
                if (i_Start) begin
                    w_state_nxt    = RUN;
                    w_x_nxt        = START_XC;
                    w_y_nxt        = START_YC;
                    w_way_nxt      = RIGHT;
                    w_cnt_nxt      = '0;
                    w_pend_vld_nxt = 1'b0;
                end
            end
            RUN: begin
                w_cnt_nxt = w_cnt_inc;
                if (w_tick) begin
                    w_pend_vld_nxt = 1'b0;
                    if (w_wall) begin
                        w_state_nxt = DEAD;
                    end else begin
                        w_x_nxt     = w_nx;
                        w_y_nxt     = w_ny;
                        w_way_nxt   = w_eff_way;
                        w_step_nxt  = 1'b1;
                        w_state_nxt = CHECK;
                    end
                end
            end
            CHECK: begin
                w_cnt_nxt   = w_cnt_inc;
                w_state_nxt = i_Hit ? DEAD : RUN;
            end
        endcase

        // Placed last so a push landing on a tick survives for next step.
        if (i_Push_Valid) begin
            w_pend_nxt     = way_t'(i_Push);
            w_pend_vld_nxt = 1'b1;
        end
    end

    assign o_Head_x = r_x;
    assign o_Head_y = r_y;
    assign o_Way    = r_way;
    assign o_Step   = r_step;
    assign o_Dead   = (r_state == DEAD);
    assign o_State  = r_state;

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Directed bench for snake_move_ctrl with a step scoreboard.
// Expected heads are queued when pushes are driven and popped on o_Step.
module tb_snake_move_ctrl;
    import snake_move_ctrl_pkg::*;

    localparam int TPS = 4;

    logic       clk = 1'b0;
    logic       i_Rst;
    logic       i_Start;
    logic       i_Push_Valid;
    logic [1:0] i_Push;
    logic       i_Hit;
    logic [6:0] o_Head_x;
    logic [6:0] o_Head_y;
    logic [1:0] o_Way;
    logic       o_Step;
    logic       o_Dead;
    logic [1:0] o_State;

    typedef struct {
        int x;
        int y;
        int w;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   m_x, m_y;
    way_t m_way;
    way_t m_pend;
    bit   m_pv;

    always #5 clk = ~clk;

    snake_move_ctrl #(
        .TICKS_PER_STEP (TPS),
        .ROWS           (48),
        .COLS           (64),
        .START_X        (24),
        .START_Y        (32)
    ) dut (
        .i_Clk        (clk),
        .i_Rst        (i_Rst),
        .i_Start      (i_Start),
        .i_Push_Valid (i_Push_Valid),
        .i_Push       (i_Push),
        .i_Hit        (i_Hit),
        .o_Head_x     (o_Head_x),
        .o_Head_y     (o_Head_y),
        .o_Way        (o_Way),
        .o_Step       (o_Step),
        .o_Dead       (o_Dead),
        .o_State      (o_State)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic way_t rev(input way_t w);
        case (w)
            UP:      return DOWN;
            DOWN:    return UP;
            RIGHT:   return LEFT;
            default: return RIGHT;
        endcase
    endfunction

    task automatic model_reset();
        m_x   = 24;
        m_y   = 32;
        m_way = RIGHT;
        m_pv  = 0;
        q.delete();
    endtask

    task automatic run_step(input int npush, input way_t d0, input way_t d1);
        way_t w;
        int   nx, ny;
        bit   wall, got;
        exp_t e;
        w = m_way;
        if (npush > 0) begin
            m_pv   = 1;
            m_pend = (npush == 2) ? d1 : d0;
        end
        if (m_pv && m_pend != rev(m_way)) w = m_pend;
        m_pv = 0;
        nx = m_x;
        ny = m_y;
        case (w)
            UP:      nx = (m_x + 127) % 128;
            DOWN:    nx = (m_x + 1) % 128;
            LEFT:    ny = (m_y + 127) % 128;
            default: ny = (m_y + 1) % 128;
        endcase
        wall = (nx >= 48) || (ny >= 64);
        if (!wall) q.push_back('{nx, ny, int'(w)});
        if (npush >= 1) begin
            i_Push_Valid = 1;
            i_Push = d0;
            cyc();
            if (npush == 2) begin
                i_Push = d1;
                cyc();
            end
            i_Push_Valid = 0;
        end
        got = 0;
        for (int i = 0; i < 2 * TPS; i++) begin
            cyc();
            if (o_Step || o_Dead) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            chk("step_timeout", 0, 1);
            if (!wall) void'(q.pop_front());
        end else if (wall) begin
            chk("wall_dead", int'(o_Dead), 1);
            chk("wall_nostep", int'(o_Step), 0);
            chk("wall_x", int'(o_Head_x), m_x);
            chk("wall_y", int'(o_Head_y), m_y);
            chk("wall_way", int'(o_Way), int'(m_way));
        end else begin
            e = q.pop_front();
            chk("step", int'(o_Step), 1);
            chk("head_x", int'(o_Head_x), e.x);
            chk("head_y", int'(o_Head_y), e.y);
            chk("way", int'(o_Way), e.w);
            chk("state_check", int'(o_State), 2);
            m_x   = e.x;
            m_y   = e.y;
            m_way = way_t'(e.w);
        end
    endtask

    task automatic restart();
        i_Start = 1;
        cyc();
        i_Start = 0;
        model_reset();
        chk("rs_state", int'(o_State), 1);
        chk("rs_x", int'(o_Head_x), 24);
        chk("rs_y", int'(o_Head_y), 32);
        chk("rs_way", int'(o_Way), 2);
        chk("rs_dead", int'(o_Dead), 0);
    endtask

    initial begin
        exp_t e;
        i_Rst = 1;
        i_Start = 0;
        i_Push_Valid = 0;
        i_Push = 0;
        i_Hit = 0;
        model_reset();
        repeat (2) cyc();
        i_Rst = 0;
        repeat (10) cyc();
        chk("idle_state", int'(o_State), 0);
        chk("idle_x", int'(o_Head_x), 24);
        chk("idle_y", int'(o_Head_y), 32);
        chk("idle_way", int'(o_Way), 2);
        chk("idle_step", int'(o_Step), 0);
        chk("idle_dead", int'(o_Dead), 0);

        // First steps land exactly at edges 4, 8, 12 after start.
        i_Start = 1;
        cyc();
        i_Start = 0;
        chk("run_state", int'(o_State), 1);
        for (int k = 1; k <= 3; k++) q.push_back('{24, 32 + k, 2});
        for (int c = 1; c <= 12; c++) begin
            cyc();
            chk("step_timing", int'(o_Step), (c % TPS == 0) ? 1 : 0);
            if (o_Step && q.size() > 0) begin
                e = q.pop_front();
                chk("t_x", int'(o_Head_x), e.x);
                chk("t_y", int'(o_Head_y), e.y);
                chk("t_way", int'(o_Way), e.w);
            end
        end
        m_x = 24;
        m_y = 35;
        m_way = RIGHT;

        run_step(1, LEFT, LEFT);
        run_step(2, UP, DOWN);

        // Top wall at (0,10) heading UP.
        run_step(1, LEFT, LEFT);
        repeat (25) run_step(0, UP, UP);
        run_step(1, UP, UP);
        repeat (24) run_step(0, UP, UP);
        chk("pre_top_x", m_x, 0);
        run_step(0, UP, UP);
        repeat (3) cyc();
        chk("frozen_x", int'(o_Head_x), 0);
        chk("frozen_y", int'(o_Head_y), 10);
        chk("frozen_dead", int'(o_Dead), 1);
        restart();

        // Bottom wall at (47,32) heading DOWN.
        run_step(1, DOWN, DOWN);
        repeat (22) run_step(0, UP, UP);
        run_step(0, UP, UP);
        restart();

        // Right wall at (24,63) heading RIGHT.
        repeat (31) run_step(0, UP, UP);
        run_step(0, UP, UP);
        restart();

        // Push landing on the tick edge is deferred to the next step.
        repeat (TPS - 1) cyc();
        i_Push_Valid = 1;
        i_Push = UP;
        cyc();
        i_Push_Valid = 0;
        chk("tickpush_step", int'(o_Step), 1);
        chk("tickpush_x", int'(o_Head_x), 24);
        chk("tickpush_y", int'(o_Head_y), 33);
        chk("tickpush_way", int'(o_Way), 2);
        m_y = 33;
        m_pv = 1;
        m_pend = UP;
        run_step(0, UP, UP);

        // Body hit during CHECK.
        i_Hit = 1;
        cyc();
        i_Hit = 0;
        chk("hit_state", int'(o_State), 3);
        chk("hit_dead", int'(o_Dead), 1);
        chk("hit_step", int'(o_Step), 0);
        chk("hit_x", int'(o_Head_x), 23);
        chk("hit_y", int'(o_Head_y), 33);
        restart();

        // Asynchronous reset in the middle of CHECK.
        run_step(0, UP, UP);
        #2;
        i_Rst = 1;
        #1;
        chk("ar_state", int'(o_State), 0);
        chk("ar_x", int'(o_Head_x), 24);
        chk("ar_y", int'(o_Head_y), 32);
        chk("ar_way", int'(o_Way), 2);
        chk("ar_step", int'(o_Step), 0);
        chk("ar_dead", int'(o_Dead), 0);
        #2;
        i_Rst = 0;
        repeat (6) begin
            cyc();
            chk("post_rst_step", int'(o_Step), 0);
            chk("post_rst_state", int'(o_State), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
